backward_propagation: RTL and testbench

Backward-pass and weight-update engine for the 2-2-1 XOR network (ReLU hidden layer, sigmoid output, Q8.8 signed fixed point). It consumes the forward pass's activations and forwarded weights/biases, plus the sample inputs and target. It computes output and hidden deltas and all nine gradients, then emits the updated weights/biases with a one-cycle valid pulse. It sits directly downstream of the forward pass and feeds the weight register bank.

---
 rtl/nn_fixed_pkg.sv | 31 +++
 rtl/param_update.sv | 26 ++
 rtl/backward_propagation.sv | 200 ++++++++++++++++++++
 tb/tb_backward_propagation.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/nn_fixed_pkg.sv
// Q8.8 signed fixed-point helpers shared by the XOR network datapath blocks.
package nn_fixed_pkg;

  localparam int unsigned FRAC_BITS = 8;
  localparam logic signed [15:0] Q_ONE = 16'sd256;
  localparam logic signed [15:0] Q_MAX = 16'sh7fff;
  localparam logic signed [15:0] Q_MIN = 16'sh8000;
  localparam int unsigned NUM_PARAMS = 9;

  function automatic logic signed [31:0] sext16(logic signed [15:0] v);
    return {{16{v[15]}}, v};
  endfunction

  function automatic logic signed [15:0] sat16(logic signed [31:0] v);
    if (v > sext16(Q_MAX)) begin
      return Q_MAX;
    end else if (v < sext16(Q_MIN)) begin
      return Q_MIN;
    end else begin
      return v[15:0];
    end
  endfunction

  // Full 32-bit product, arithmetic shift back to Q8.8 (floors), then saturate.
  function automatic logic signed [15:0] mul_q(logic signed [15:0] a, logic signed [15:0] b);
    logic signed [31:0] prod;
    prod = sext16(a) * sext16(b);
    return sat16(prod >>> FRAC_BITS);
  endfunction

endpackage

// File: rtl/param_update.sv
// One SGD step for a single parameter: p - (g >>> LR_SHIFT), saturated to 16 bits.
module param_update
  import nn_fixed_pkg::*;
#(
  parameter int unsigned LR_SHIFT = 2
) (
  input  logic signed [15:0] param,
  input  logic signed [15:0] grad,
  output logic signed [15:0] param_new
);

  logic signed [16:0] p_ext;
  logic signed [16:0] g_ext;
  logic signed [16:0] step;
  logic signed [16:0] diff;

  // 17 bits hold any 16-bit difference, so saturation only happens once at the end.
  always_comb begin
    p_ext     = {param[15], param};
    g_ext     = {grad[15], grad};
    step      = g_ext >>> LR_SHIFT;
    diff      = p_ext - step;
    param_new = sat16({{15{diff[16]}}, diff});
  end

endmodule

// File: rtl/backward_propagation.sv
// Backward pass and weight update for the 2-2-1 XOR network (Q8.8).
// Define BP_GRAD_CLIP_EN to clamp every gradient to [-GRAD_CLIP, +GRAD_CLIP].
module backward_propagation
  import nn_fixed_pkg::*;
#(
  parameter int unsigned LR_SHIFT = 2
`ifdef BP_GRAD_CLIP_EN
  ,
  parameter logic signed [15:0] GRAD_CLIP = 16'sd1024
`endif
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               enable_bp,
  input  logic signed [15:0] x1,
  input  logic signed [15:0] x2,
  input  logic signed [15:0] target,
  input  logic signed [15:0] h1,
  input  logic signed [15:0] h2,
  input  logic signed [15:0] y,
  input  logic signed [15:0] w11,
  input  logic signed [15:0] w12,
  input  logic signed [15:0] w21,
  input  logic signed [15:0] w22,
  input  logic signed [15:0] w31,
  input  logic signed [15:0] w32,
  input  logic signed [15:0] b1,
  input  logic signed [15:0] b2,
  input  logic signed [15:0] b3,
  output logic signed [15:0] w11_new,
  output logic signed [15:0] w12_new,
  output logic signed [15:0] w21_new,
  output logic signed [15:0] w22_new,
  output logic signed [15:0] w31_new,
  output logic signed [15:0] w32_new,
  output logic signed [15:0] b1_new,
  output logic signed [15:0] b2_new,
  output logic signed [15:0] b3_new,
  output logic               busy,
  output logic               bp_valid
);

  typedef enum logic [2:0] {
    StIdle,
    StOutDelta,
    StHidDelta,
    StGrads,
    StUpdate,
    StDone
  } state_e;

  state_e state_q, state_d;

  // Parameter order everywhere: w11 w12 w21 w22 w31 w32 b1 b2 b3.
  logic signed [15:0] param_in  [NUM_PARAMS];
  logic signed [15:0] param_q   [NUM_PARAMS];
  logic signed [15:0] grad_raw  [NUM_PARAMS];
  logic signed [15:0] grad_d    [NUM_PARAMS];
  logic signed [15:0] grad_q    [NUM_PARAMS];
  logic signed [15:0] upd       [NUM_PARAMS];
  logic signed [15:0] new_q     [NUM_PARAMS];

  logic signed [15:0] x1_q, x2_q, tgt_q, h1_q, h2_q, y_q;
  logic signed [15:0] d1_q, d2_q, d3_q;
  logic signed [15:0] d1_d, d2_d, d3_d;

  always_comb begin
    param_in[0] = w11;
    param_in[1] = w12;
    param_in[2] = w21;
    param_in[3] = w22;
    param_in[4] = w31;
    param_in[5] = w32;
    param_in[6] = b1;
    param_in[7] = b2;
    param_in[8] = b3;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:     if (enable_bp) state_d = StOutDelta;
      StOutDelta: state_d = StHidDelta;
      StHidDelta: state_d = StGrads;
      StGrads:    state_d = StUpdate;
      StUpdate:   state_d = StDone;
      StDone:     state_d = StIdle;
      default:    state_d = StIdle;
    endcase
  end

  // Sigmoid + cross-entropy: output delta is simply y - target.
  always_comb begin
    d3_d = sat16(sext16(y_q) - sext16(tgt_q));
    d1_d = (h1_q > 16'sd0) ? mul_q(param_q[4], d3_q) : 16'sd0;
    d2_d = (h2_q > 16'sd0) ? mul_q(param_q[5], d3_q) : 16'sd0;
  end

  always_comb begin
    grad_raw[0] = mul_q(d1_q, x1_q);
    grad_raw[1] = mul_q(d1_q, x2_q);
    grad_raw[2] = mul_q(d2_q, x1_q);
    grad_raw[3] = mul_q(d2_q, x2_q);
    grad_raw[4] = mul_q(d3_q, h1_q);
    grad_raw[5] = mul_q(d3_q, h2_q);
    grad_raw[6] = d1_q;
    grad_raw[7] = d2_q;
    grad_raw[8] = d3_q;
    for (int i = 0; i < NUM_PARAMS; i++) begin
`ifdef BP_GRAD_CLIP_EN
      if (grad_raw[i] > GRAD_CLIP) begin
        grad_d[i] = GRAD_CLIP;
      end else if (grad_raw[i] < -GRAD_CLIP) begin
        grad_d[i] = -GRAD_CLIP;
      end else begin
        grad_d[i] = grad_raw[i];
      end
`else
      grad_d[i] = grad_raw[i];
`endif
    end
  end

  for (genvar i = 0; i < NUM_PARAMS; i++) begin : g_upd
    param_update #(
      .LR_SHIFT(LR_SHIFT)
    ) u_param_update (
      .param    (param_q[i]),
      .grad     (grad_q[i]),
      .param_new(upd[i])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x1_q  <= '0;
      x2_q  <= '0;
      tgt_q <= '0;
      h1_q  <= '0;
      h2_q  <= '0;
      y_q   <= '0;
      d1_q  <= '0;
      d2_q  <= '0;
      d3_q  <= '0;
      for (int i = 0; i < NUM_PARAMS; i++) begin
        param_q[i] <= '0;
        grad_q[i]  <= '0;
        new_q[i]   <= '0;
      end
    end else begin
      case (state_q)
        StIdle: begin
          if (enable_bp) begin
            x1_q  <= x1;
            x2_q  <= x2;
            tgt_q <= target;
            h1_q  <= h1;
            h2_q  <= h2;
            y_q   <= y;
            for (int i = 0; i < NUM_PARAMS; i++) param_q[i] <= param_in[i];
          end
        end
        StOutDelta: d3_q <= d3_d;
        StHidDelta: begin
          d1_q <= d1_d;
          d2_q <= d2_d;
        end
        StGrads: begin
          for (int i = 0; i < NUM_PARAMS; i++) grad_q[i] <= grad_d[i];
        end
        StUpdate: begin
          for (int i = 0; i < NUM_PARAMS; i++) new_q[i] <= upd[i];
        end
        default: ;
      endcase
    end
  end

  assign busy     = (state_q != StIdle);
  assign bp_valid = (state_q == StDone);

  assign w11_new = new_q[0];
  assign w12_new = new_q[1];
  assign w21_new = new_q[2];
  assign w22_new = new_q[3];
  assign w31_new = new_q[4];
  assign w32_new = new_q[5];
  assign b1_new  = new_q[6];
  assign b2_new  = new_q[7];
  assign b3_new  = new_q[8];

endmodule

// File: tb/tb_backward_propagation.sv
// Self-checking bench for backward_propagation: integer reference model plus directed vectors.
module tb_backward_propagation;

  localparam int LR   = 2;
  localparam int CLIP = 1024;

  typedef logic [8:0][15:0] pvec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic enable_bp = 1'b0;
  logic signed [15:0] x1 = '0, x2 = '0, target = '0, h1 = '0, h2 = '0, y = '0;
  pvec_t pin = '0;
  logic signed [15:0] w11_new, w12_new, w21_new, w22_new, w31_new, w32_new;
  logic signed [15:0] b1_new, b2_new, b3_new;
  logic busy, bp_valid;
  pvec_t dut_new;

  int n_cmp = 0;
  int n_bad = 0;
  logic chk_en = 1'b0;

  string pname [9] = '{"w11_new", "w12_new", "w21_new", "w22_new", "w31_new", "w32_new",
                       "b1_new", "b2_new", "b3_new"};

  always #5 clk = ~clk;

  backward_propagation dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .enable_bp(enable_bp),
    .x1       (x1),
    .x2       (x2),
    .target   (target),
    .h1       (h1),
    .h2       (h2),
    .y        (y),
    .w11      (pin[0]),
    .w12      (pin[1]),
    .w21      (pin[2]),
    .w22      (pin[3]),
    .w31      (pin[4]),
    .w32      (pin[5]),
    .b1       (pin[6]),
    .b2       (pin[7]),
    .b3       (pin[8]),
    .w11_new  (w11_new),
    .w12_new  (w12_new),
    .w21_new  (w21_new),
    .w22_new  (w22_new),
    .w31_new  (w31_new),
    .w32_new  (w32_new),
    .b1_new   (b1_new),
    .b2_new   (b2_new),
    .b3_new   (b3_new),
    .busy     (busy),
    .bp_valid (bp_valid)
  );

  assign dut_new = {b3_new, b2_new, b1_new, w32_new, w31_new, w22_new, w21_new, w12_new, w11_new};

  // ---------------- reference model ----------------
  function automatic int sat(int v);
    if (v > 32767) return 32767;
    if (v < -32768) return -32768;
    return v;
  endfunction

  function automatic int fdiv(int a, int d);
    if (a >= 0) return a / d;
    return -((-a + d - 1) / d);
  endfunction

  function automatic int mq(int a, int b);
    return sat(fdiv(a * b, 256));
  endfunction

  function automatic int sv(logic [15:0] v);
    return int'($signed(v));
  endfunction

  function automatic pvec_t calc(int vx1, int vx2, int vt, int vh1, int vh2, int vy, pvec_t pv);
    int d1, d2, d3;
    int g [9];
    pvec_t r;
    d3 = sat(vy - vt);
    d1 = (vh1 > 0) ? mq(sv(pv[4]), d3) : 0;
    d2 = (vh2 > 0) ? mq(sv(pv[5]), d3) : 0;
    g[0] = mq(d1, vx1);
    g[1] = mq(d1, vx2);
    g[2] = mq(d2, vx1);
    g[3] = mq(d2, vx2);
    g[4] = mq(d3, vh1);
    g[5] = mq(d3, vh2);
    g[6] = d1;
    g[7] = d2;
    g[8] = d3;
    for (int i = 0; i < 9; i++) begin
`ifdef BP_GRAD_CLIP_EN
      if (g[i] > CLIP) g[i] = CLIP;
      if (g[i] < -CLIP) g[i] = -CLIP;
`endif
      r[i] = 16'(sat(sv(pv[i]) - fdiv(g[i], 1 << LR)));
    end
    return r;
  endfunction

  function automatic pvec_t mkp(int a11, int a12, int a21, int a22, int a31, int a32,
                                int c1, int c2, int c3);
    pvec_t r;
    r[0] = 16'(a11); r[1] = 16'(a12); r[2] = 16'(a21); r[3] = 16'(a22);
    r[4] = 16'(a31); r[5] = 16'(a32); r[6] = 16'(c1);  r[7] = 16'(c2); r[8] = 16'(c3);
    return r;
  endfunction

  // Timeline: phase counts edges since start acceptance; results land on the 4th edge after.
  int    ph = 0;
  pvec_t pend = '0;
  pvec_t exp_new = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ph      <= 0;
      pend    <= '0;
      exp_new <= '0;
    end else if (ph == 0) begin
      if (enable_bp) begin
        ph   <= 1;
        pend <= calc(sv(x1), sv(x2), sv(target), sv(h1), sv(h2), sv(y), pin);
      end
    end else if (ph == 4) begin
      ph      <= 5;
      exp_new <= pend;
    end else if (ph == 5) begin
      ph <= 0;
    end else begin
      ph <= ph + 1;
    end
  end

  task automatic check(input string nm, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, req, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("busy", int'(busy), (ph != 0) ? 1 : 0);
      check("bp_valid", int'(bp_valid), (ph == 5) ? 1 : 0);
      for (int i = 0; i < 9; i++) check(pname[i], sv(dut_new[i]), sv(exp_new[i]));
    end
  end

  // ---------------- stimulus ----------------
  task automatic load(int vx1, int vx2, int vt, int vh1, int vh2, int vy, pvec_t pv);
    x1 = 16'(vx1); x2 = 16'(vx2); target = 16'(vt);
    h1 = 16'(vh1); h2 = 16'(vh2); y = 16'(vy);
    pin = pv;
  endtask

  // Returns 2 time units after E4, where bp_valid must be high.
  task automatic run_op();
    @(posedge clk); #2 enable_bp = 1'b1;
    @(posedge clk); #2 enable_bp = 1'b0;
    repeat (3) @(posedge clk);
    #1 check("valid 4 edges before", int'(bp_valid), 0);
    @(posedge clk); #2;
    check("valid at E4+", int'(bp_valid), 1);
  endtask

  task automatic finish_op();
    @(posedge clk); #2;
    check("valid drops at E5", int'(bp_valid), 0);
    check("busy drops at E5", int'(busy), 0);
  endtask

  initial begin
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #2 chk_en = 1'b1;
    check("reset w31_new", sv(w31_new), 0);
    check("reset busy", int'(busy), 0);
    @(posedge clk); #2 rst_n = 1'b1;

    // Nominal step
    load(256, 0, 256, 256, 0, 128, mkp(256, 0, 0, 0, 256, 256, 0, 0, 0));
    run_op();
    check("nom w31_new", sv(w31_new), 288);
    check("nom b3_new", sv(b3_new), 32);
    check("nom w11_new", sv(w11_new), 288);
    check("nom b1_new", sv(b1_new), 32);
    check("nom w32_new", sv(w32_new), 256);
    check("nom w12_new", sv(w12_new), 0);
    finish_op();

    // Update saturation
    load(0, 0, 256, 32767, 0, 0, mkp(0, 0, 0, 0, 32767, 0, 0, 0, 0));
    run_op();
    check("sat w31_new", sv(w31_new), 32767);
    finish_op();

    // Clip-sensitive vector
    load(0, 0, 256, 32767, 0, 0, mkp(0, 0, 0, 0, 1000, 0, 0, 0, 0));
    run_op();
`ifdef BP_GRAD_CLIP_EN
    check("clip w31_new", sv(w31_new), 1256);
`else
    check("noclip w31_new", sv(w31_new), 9192);
`endif
    finish_op();

    // ReLU gating: both hidden units inactive
    load(256, 256, 0, 0, -5, 128, mkp(100, -200, 300, -400, 256, 256, 50, -60, 0));
    run_op();
    check("relu w11_new", sv(w11_new), 100);
    check("relu w12_new", sv(w12_new), -200);
    check("relu w21_new", sv(w21_new), 300);
    check("relu w22_new", sv(w22_new), -400);
    check("relu b1_new", sv(b1_new), 50);
    check("relu b2_new", sv(b2_new), -60);
    check("relu w32_new", sv(w32_new), 257);
    check("relu b3_new", sv(b3_new), -32);
    finish_op();

    // Handshake: enable held, inputs disturbed after E2
    load(256, 0, 256, 256, 0, 0, mkp(256, 0, 0, 0, 256, 256, 0, 0, 0));
    @(posedge clk); #2 enable_bp = 1'b1;
    @(posedge clk);                      // E0
    @(posedge clk);                      // E1
    @(posedge clk); #2;                  // E2
    load(-1000, 777, 0, 5000, 3000, 20000, mkp(1, 2, 3, 4, 5, 6, 7, 8, 9));
    @(posedge clk);                      // E3
    @(posedge clk); #2;                  // E4
    check("hs bp_valid", int'(bp_valid), 1);
    check("hs w31_new", sv(w31_new), 320);
    check("hs w11_new", sv(w11_new), 320);
    check("hs b3_new", sv(b3_new), 64);
    check("hs busy E4", int'(busy), 1);
    @(posedge clk); #2;                  // E5
    check("hs busy E5", int'(busy), 0);
    @(posedge clk); #2;                  // E6
    check("hs restart E6", int'(busy), 1);
    enable_bp = 1'b0;
    repeat (6) @(posedge clk);
    #2;

    // Reset during GRADS
    load(256, 0, 256, 256, 0, 128, mkp(256, 0, 0, 0, 256, 256, 0, 0, 0));
    @(posedge clk); #2 enable_bp = 1'b1;
    @(posedge clk); #2 enable_bp = 1'b0; // E0
    @(posedge clk);                      // E1
    @(posedge clk); #2 rst_n = 1'b0;     // in GRADS
    #1;
    check("rst mid w11_new", sv(w11_new), 0);
    check("rst mid busy", int'(busy), 0);
    check("rst mid bp_valid", int'(bp_valid), 0);
    @(posedge clk); #2 rst_n = 1'b1;
    repeat (5) @(posedge clk);
    run_op();
    check("post-rst w31_new", sv(w31_new), 288);
    check("post-rst b1_new", sv(b1_new), 32);
    finish_op();

    repeat (3) @(posedge clk);
    #2 chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
